// File: rtl/l1a_bus_pkg.sv
// Shared types and constants for the level-1a host bus sequencer.
package l1a_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    HOST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned HOST_WAIT_MAX     = 7;
  localparam logic [7:0]  HOST_BANK_DEFAULT = 8'hFF;

endpackage

// File: rtl/l1a_phi0_sync.sv
// Synchronises the asynchronous host phi0 into the CPU clock domain and
// flags its rising and falling edges.
module l1a_phi0_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstb,
  input  logic i_phi0,
  output logic o_phi0_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_phi0_d;

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      r_sync   <= '0;
      r_phi0_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_phi0};
      r_phi0_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_phi0_s = r_sync[SYNC_STAGES-1];
  assign o_rise   = o_phi0_s & ~r_phi0_d;
  assign o_fall   = ~o_phi0_s & r_phi0_d;

endmodule

// File: rtl/l1a_host_bus_seq.sv
// 65816 cycle decoder and host (6502) bus sequencer for the level-1a CPLD.
// Optional: define L1A_HOST_VEC_REMAP_EN to route all vector pulls to the host.
module l1a_host_bus_seq
  import l1a_bus_pkg::*;
#(
  parameter int unsigned RAM_HI_W    = 2,
  parameter logic [7:0]  HOST_BANK   = HOST_BANK_DEFAULT,
  parameter int unsigned HOST_WAIT   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                cpu_clk_phi2,
  input  logic                rstb,
  input  logic                cpu_vda,
  input  logic                cpu_vpa,
  input  logic                cpu_vpb,
  input  logic                cpu_rdnw,
  input  logic [7:0]          cpu_bank,
  input  logic [7:0]          cpu_din,
  input  logic                host_phi0,
  input  logic [7:0]          host_din,
  output logic                rdy,
  output logic                ram_ceb,
  output logic [RAM_HI_W-1:0] ram_addr_hi,
  output logic                host_rdnw,
  output logic [7:0]          host_dout,
  output logic                host_data_oe,
  output logic [7:0]          cpu_dout,
  output logic                cpu_data_oe,
  output logic                host_busy
);

  localparam logic [2:0] L_WAIT = 3'(HOST_WAIT);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_per, w_per_nxt;
  logic [7:0] r_rd_q, w_rd_q_nxt;

  logic w_valid, w_host_req, w_ram_req;
  logic w_phi0_s, w_rise, w_fall, w_fall_q;

  assign w_valid = (cpu_vda | cpu_vpa) & rstb;
`ifdef L1A_HOST_VEC_REMAP_EN
  assign w_host_req = w_valid & ((cpu_bank == HOST_BANK) | ~cpu_vpb);
`else
  assign w_host_req = w_valid & (cpu_bank == HOST_BANK);
`endif
  assign w_ram_req = w_valid & ~w_host_req;

  assign ram_ceb     = ~w_ram_req;
  assign ram_addr_hi = cpu_bank[RAM_HI_W-1:0];
  assign cpu_dout    = r_rd_q;

  l1a_phi0_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (cpu_clk_phi2),
    .i_rstb  (rstb),
    .i_phi0  (host_phi0),
    .o_phi0_s(w_phi0_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // A fall is only honoured while the synchronised level is low.
  assign w_fall_q = w_fall & ~w_phi0_s;

  always_ff @(posedge cpu_clk_phi2) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_per   <= '0;
      r_rd_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_per   <= w_per_nxt;
      r_rd_q  <= w_rd_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_per_nxt    = r_per;
    w_rd_q_nxt   = r_rd_q;
    rdy          = 1'b1;
    host_rdnw    = 1'b1;
    host_data_oe = 1'b0;
    host_dout    = cpu_din;
    host_busy    = 1'b0;
    cpu_data_oe  = 1'b0;
    case (r_state)
      IDLE: begin
        rdy = ~w_host_req;
        if (w_host_req) w_state_nxt = ALIGN;
      end
      ALIGN: begin
        rdy = 1'b0;
        if (w_rise) begin
          w_state_nxt = HOST;
          w_per_nxt   = '0;
        end
      end
      HOST: begin
        rdy          = 1'b0;
        host_busy    = 1'b1;
        host_rdnw    = cpu_rdnw;
        host_data_oe = ~cpu_rdnw;
        // Rise takes priority so a coincident fall is dropped.
        if (w_rise) begin
          w_per_nxt = r_per + 3'd1;
        end else if (w_fall_q && (r_per == L_WAIT)) begin
          w_rd_q_nxt  = host_din;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        cpu_data_oe = cpu_rdnw;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1a_host_bus_seq.sv
// Directed bench for l1a_host_bus_seq: decode table plus host access sequences.
module tb_l1a_host_bus_seq;

  logic       clk = 1'b0;
  logic       rstb;
  logic       cpu_vda, cpu_vpa, cpu_vpb, cpu_rdnw;
  logic [7:0] cpu_bank, cpu_din, host_din;
  logic       host_phi0;

  logic       rdy_o [2];
  logic       ram_ceb_o [2];
  logic [1:0] hi_o [2];
  logic       host_rdnw_o [2];
  logic [7:0] host_dout_o [2];
  logic       host_oe_o [2];
  logic [7:0] cpu_dout_o [2];
  logic       cpu_oe_o [2];
  logic       busy_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Host phi0: 8 CPU clocks per period.
  initial begin
    host_phi0 = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      host_phi0 = ~host_phi0;
    end
  end

  l1a_host_bus_seq #(.RAM_HI_W(2), .HOST_BANK(8'hFF), .HOST_WAIT(0), .SYNC_STAGES(2)) u_dut0 (
    .cpu_clk_phi2(clk), .rstb(rstb), .cpu_vda(cpu_vda), .cpu_vpa(cpu_vpa), .cpu_vpb(cpu_vpb),
    .cpu_rdnw(cpu_rdnw), .cpu_bank(cpu_bank), .cpu_din(cpu_din), .host_phi0(host_phi0),
    .host_din(host_din), .rdy(rdy_o[0]), .ram_ceb(ram_ceb_o[0]), .ram_addr_hi(hi_o[0]),
    .host_rdnw(host_rdnw_o[0]), .host_dout(host_dout_o[0]), .host_data_oe(host_oe_o[0]),
    .cpu_dout(cpu_dout_o[0]), .cpu_data_oe(cpu_oe_o[0]), .host_busy(busy_o[0]));

  l1a_host_bus_seq #(.RAM_HI_W(2), .HOST_BANK(8'hFF), .HOST_WAIT(1), .SYNC_STAGES(2)) u_dut1 (
    .cpu_clk_phi2(clk), .rstb(rstb), .cpu_vda(cpu_vda), .cpu_vpa(cpu_vpa), .cpu_vpb(cpu_vpb),
    .cpu_rdnw(cpu_rdnw), .cpu_bank(cpu_bank), .cpu_din(cpu_din), .host_phi0(host_phi0),
    .host_din(host_din), .rdy(rdy_o[1]), .ram_ceb(ram_ceb_o[1]), .ram_addr_hi(hi_o[1]),
    .host_rdnw(host_rdnw_o[1]), .host_dout(host_dout_o[1]), .host_data_oe(host_oe_o[1]),
    .cpu_dout(cpu_dout_o[1]), .cpu_data_oe(cpu_oe_o[1]), .host_busy(busy_o[1]));

  typedef struct {
    logic       vda, vpa, vpb;
    logic [7:0] bank;
    logic       exp_ceb, exp_rdy;
    logic [1:0] exp_hi;
  } vec_t;

  vec_t vecs [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_vda = 1'b0; cpu_vpa = 1'b0; cpu_vpb = 1'b1; cpu_rdnw = 1'b1;
    cpu_bank = 8'h00; cpu_din = 8'h00;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (40) tick();
  endtask

  // Runs one host access on instance k; busy span is 4*(2*wait_n+1) clocks.
  task automatic do_access(input int k, input int unsigned wait_n, input logic rd,
                           input logic [7:0] hdin, input logic [7:0] cdin, input logic keep);
    int unsigned busy_n = 0;
    logic done = 1'b0;
    cpu_vda = 1'b1; cpu_vpa = 1'b0; cpu_vpb = 1'b1; cpu_bank = 8'hFF;
    cpu_rdnw = rd; cpu_din = cdin; host_din = hdin;
    #1;
    chk1("req_rdy", rdy_o[k], 1'b0);
    chk1("req_ceb", ram_ceb_o[k], 1'b1);
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (rdy_o[k]) begin
        done = 1'b1;
        chk1("done_busy", busy_o[k], 1'b0);
        chk1("done_cpu_oe", cpu_oe_o[k], rd);
        chk8("done_cpu_dout", cpu_dout_o[k], hdin);
      end else if (busy_o[k]) begin
        busy_n++;
        chk1("host_rdnw", host_rdnw_o[k], rd);
        chk1("host_oe", host_oe_o[k], ~rd);
        chk8("host_dout", host_dout_o[k], cdin);
        chk1("host_cpu_oe", cpu_oe_o[k], 1'b0);
      end else begin
        chk1("wait_rdnw", host_rdnw_o[k], 1'b1);
        chk1("wait_oe", host_oe_o[k], 1'b0);
        chk1("wait_cpu_oe", cpu_oe_o[k], 1'b0);
      end
    end
    chk1("access_timeout", done, 1'b1);
    chk8("busy_len", 8'(busy_n), 8'(4 * (2 * wait_n + 1)));
    tick();
    chk1("post_cpu_oe", cpu_oe_o[k], 1'b0);
    if (!keep) begin
      cpu_vda = 1'b0;
      #1;
      chk1("post_rdy", rdy_o[k], 1'b1);
    end
  endtask

  initial begin
    logic seen;
`ifdef L1A_HOST_VEC_REMAP_EN
    localparam logic VEC_HOST = 1'b1;
`else
    localparam logic VEC_HOST = 1'b0;
`endif
    vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 2'b10};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 2'b01};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 2'b11};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 2'b11};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 2'b11};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, VEC_HOST, ~VEC_HOST, 2'b00};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 2'b10};

    rstb = 1'b0;
    host_din = 8'h00;
    idle_inputs();
    repeat (3) tick();
    rstb = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk1("rst_rdy", rdy_o[k], 1'b1);
      chk1("rst_ceb", ram_ceb_o[k], 1'b1);
      chk1("rst_rdnw", host_rdnw_o[k], 1'b1);
      chk1("rst_host_oe", host_oe_o[k], 1'b0);
      chk1("rst_cpu_oe", cpu_oe_o[k], 1'b0);
      chk1("rst_busy", busy_o[k], 1'b0);
      chk8("rst_cpu_dout", cpu_dout_o[k], 8'h00);
    end

    // Combinational decode; inputs return to idle before each edge.
    for (int i = 0; i < 8; i++) begin
      cpu_vda = vecs[i].vda; cpu_vpa = vecs[i].vpa; cpu_vpb = vecs[i].vpb;
      cpu_bank = vecs[i].bank;
      #1;
      chk1("vec_ceb", ram_ceb_o[0], vecs[i].exp_ceb);
      chk1("vec_rdy", rdy_o[0], vecs[i].exp_rdy);
      chk8("vec_hi", {6'b0, hi_o[0]}, {6'b0, vecs[i].exp_hi});
      chk1("vec_busy", busy_o[0], 1'b0);
      chk1("vec_rdy1", rdy_o[1], vecs[i].exp_rdy);
      idle_inputs();
      tick();
    end

    // Sustained RAM traffic: zero wait, no host activity.
    cpu_vda = 1'b1; cpu_bank = 8'h02;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk1("ram_ceb", ram_ceb_o[0], 1'b0);
      chk8("ram_hi", {6'b0, hi_o[0]}, 8'h02);
      chk1("ram_rdy", rdy_o[0], 1'b1);
      chk1("ram_busy", busy_o[0], 1'b0);
      tick();
    end
    drain();

    do_access(0, 0, 1'b1, 8'hA5, 8'h00, 1'b0);
    drain();
    do_access(1, 1, 1'b0, 8'h00, 8'h3C, 1'b0);
    drain();
    do_access(0, 0, 1'b1, 8'h5A, 8'h00, 1'b1);
    do_access(0, 0, 1'b1, 8'hC3, 8'h00, 1'b0);
    drain();

    // Reset pulse in the middle of a host write.
    cpu_vda = 1'b1; cpu_bank = 8'hFF; cpu_rdnw = 1'b0; cpu_din = 8'h77;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      seen = busy_o[1];
    end
    chk1("mid_busy_timeout", seen, 1'b1);
    tick();
    chk1("pre_rst_oe", host_oe_o[1], 1'b1);
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    cpu_vda = 1'b0;
    #1;
    chk1("mid_rst_rdy", rdy_o[1], 1'b1);
    chk1("mid_rst_oe", host_oe_o[1], 1'b0);
    chk1("mid_rst_rdnw", host_rdnw_o[1], 1'b1);
    chk1("mid_rst_busy", busy_o[1], 1'b0);
    tick();
    chk1("mid_rst_busy2", busy_o[1], 1'b0);
    drain();

    // Vector pull from bank 0.
    cpu_vda = 1'b1; cpu_vpb = 1'b0; cpu_bank = 8'h00; cpu_rdnw = 1'b1; host_din = 8'h96;
    #1;
    chk1("vp_ceb", ram_ceb_o[0], VEC_HOST);
    chk1("vp_rdy", rdy_o[0], ~VEC_HOST);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      seen = rdy_o[0];
    end
    chk1("vp_complete", seen, 1'b1);
    chk8("vp_dout", cpu_dout_o[0], VEC_HOST ? 8'h96 : 8'h00);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
